// File: rtl/frame_api.sv
// rtl/frame_api.sv - aggregating package re-exporting the frame-link definitions
package frame_api;
  import frame_pkg::*;
  export frame_pkg::*;
endpackage

// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared frame-link states, line levels and parity helper
package frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } frame_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Even parity over the low w bits of d; bits at or above w are ignored.
  function automatic logic even_parity(input logic [15:0] d, input int w);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i < w) p = p ^ d[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/frame_bit_timer.sv
// rtl/frame_bit_timer.sv - per-bit divider, ticks on the last cycle of each line bit
module frame_bit_timer #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i)             cnt_d = '0;
    else if (cnt_q == LAST) cnt_d = '0;
    else                   cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/frame_serial_tx.sv
// rtl/frame_serial_tx.sv - frame-link transmitter: start, LSB-first data, optional even parity, stop
module frame_serial_tx
  import frame_api::*;
#(
  parameter int DATA_W    = 8,
  parameter int DIV       = 4,
  parameter int PARITY_EN = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  frame_state_e      state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bitcnt_q, bitcnt_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              busy_q;
  logic              tick;

  frame_bit_timer #(.DIV(DIV)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (state_q != IDLE),
    .tick_o (tick)
  );

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    par_d      = par_q;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = in_data;
          par_d   = even_parity(16'(in_data), DATA_W);
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          state_d  = DATA;
          bitcnt_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_d  = shreg_q >> 1;
          bitcnt_d = bitcnt_q + BW'(1);
          if (bitcnt_q == LAST_BIT) state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (tick) state_d = STOP;
      end
      STOP: begin
        if (tick) begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the state being entered so tx changes on the same edge as the state.
    case (state_d)
      START:   tx_d = START_BIT;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_d;
      STOP:    tx_d = STOP_BIT;
      default: tx_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      par_q    <= 1'b0;
      tx_q     <= LINE_IDLE;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign in_ready = (state_q == IDLE);
  assign tx       = tx_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_frame_serial_tx.sv
// tb/tb_frame_serial_tx.sv - directed scoreboard bench for frame_serial_tx
module tb_frame_serial_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data0, in_data1;
  logic       in_valid0, in_valid1;
  logic       in_ready0, in_ready1, tx0, tx1, busy0, busy1, done0, done1;
  int         sel;
  int         checks = 0;
  int         passes = 0;
  int         fails = 0;
  logic       exp_q[$];
  logic       cur_tx, cur_ready, cur_busy, cur_done;

  always #5 clk = ~clk;

  frame_serial_tx #(.DATA_W(8), .DIV(4), .PARITY_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .tx(tx0), .busy(busy0), .frame_done(done0)
  );

  frame_serial_tx #(.DATA_W(8), .DIV(4), .PARITY_EN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .tx(tx1), .busy(busy1), .frame_done(done1)
  );

  assign cur_tx    = (sel == 1) ? tx1 : tx0;
  assign cur_ready = (sel == 1) ? in_ready1 : in_ready0;
  assign cur_busy  = (sel == 1) ? busy1 : busy0;
  assign cur_done  = (sel == 1) ? done1 : done0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    if (sel == 1) begin in_valid1 = v; in_data1 = d; end
    else begin in_valid0 = v; in_data0 = d; end
  endtask

  // Called at a negedge with in_valid already driven; checks every cycle of the frame.
  task automatic frame(input logic [7:0] w, input int pe, input logic hold, input logic [7:0] nxt,
                       input int inj, input int abort_c, input logic immediate);
    int   total, waited, cyc;
    logic e;
    total  = 4 * (2 + 8 + pe);
    waited = 0;
    while (!cur_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!cur_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      return;
    end
    if (immediate) chk("b2b_accept_wait", waited, 0);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(w[i]);
    if (pe != 0) exp_q.push_back(^w);
    exp_q.push_back(1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(hold, nxt);
    for (int s = 0; s < 2 + 8 + pe; s++) begin
      e = exp_q.pop_front();
      for (int c = 0; c < 4; c++) begin
        cyc = 4 * s + c + 1;
        if (cyc == inj) drive(1'b1, 8'h3C);
        else if (cyc == inj + 1) drive(1'b0, 8'h00);
        if (cyc == abort_c) begin
          rst_n = 1'b0;
          #1;
          chk("abort_tx", cur_tx, 1);
          chk("abort_busy", cur_busy, 0);
          chk("abort_ready", cur_ready, 1);
          exp_q.delete();
          return;
        end
        chk($sformatf("tx_%02h_c%0d", w, cyc), cur_tx, e);
        chk($sformatf("done_%02h_c%0d", w, cyc), cur_done, (cyc == total));
        chk($sformatf("ready_%02h_c%0d", w, cyc), cur_ready, 0);
        chk($sformatf("busy_%02h_c%0d", w, cyc), cur_busy, 1);
        @(negedge clk);
      end
    end
    chk($sformatf("end_ready_%02h", w), cur_ready, 1);
    chk($sformatf("end_tx_%02h", w), cur_tx, 1);
    chk($sformatf("end_busy_%02h", w), cur_busy, 0);
    chk($sformatf("end_done_%02h", w), cur_done, 0);
  endtask

  initial begin
    sel = 0;
    rst_n = 1'b0;
    in_valid0 = 1'b1; in_data0 = 8'hFF;
    in_valid1 = 1'b1; in_data1 = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      chk("rst_tx0", tx0, 1);        chk("rst_ready0", in_ready0, 1);
      chk("rst_busy0", busy0, 0);    chk("rst_done0", done0, 0);
      chk("rst_tx1", tx1, 1);        chk("rst_busy1", busy1, 0);
    end
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy0, 0);
    chk("post_rst_tx", tx0, 1);

    drive(1'b1, 8'hA5);
    frame(8'hA5, 0, 1'b0, 8'h00, -10, -1, 1'b0);

    sel = 1;
    drive(1'b1, 8'h07);
    frame(8'h07, 1, 1'b0, 8'h00, -10, -1, 1'b0);
    sel = 0;

    drive(1'b1, 8'h00);
    frame(8'h00, 0, 1'b1, 8'hFF, -10, -1, 1'b0);
    frame(8'hFF, 0, 1'b0, 8'h00, -10, -1, 1'b1);

    @(negedge clk);
    drive(1'b1, 8'h81);
    frame(8'h81, 0, 1'b0, 8'h00, 15, -1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("no_second_busy_%0d", i), busy0, 0);
      chk($sformatf("no_second_tx_%0d", i), tx0, 1);
    end

    drive(1'b1, 8'hC3);
    frame(8'hC3, 0, 1'b0, 8'h00, -10, 18, 1'b0);
    @(negedge clk);
    chk("in_rst_tx", tx0, 1);
    chk("in_rst_busy", busy0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_abort_idle_busy", busy0, 0);
    drive(1'b1, 8'h5A);
    frame(8'h5A, 0, 1'b0, 8'h00, -10, -1, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
